fp32_add: RTL and testbench

Fully pipelined IEEE-754 single-precision adder: c = a + b, one operation accepted per clock. Used in the rendering datapath wherever fp32 sums or differences are needed. Round-to-nearest-even; subnormals flushed to zero. Fixed latency with a valid bit carried alongside the data.

---
 rtl/fp32_add.sv | 192 +++++++++++++++++++
 tb/tb_fp32_add.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_add.sv
// Five-stage pipelined IEEE-754 binary32 adder, round-to-nearest-even, flush-to-zero.
// Special operands (NaN, inf, zero+zero) resolve in the first stage and ride the pipe.
module fp32_add (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        valid_out,
  output logic [31:0] c_out
);

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 24;
  localparam int unsigned AW = MW + 3;
  localparam int unsigned SW = AW + 1;
  localparam int unsigned XW = EW + 2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [AW-1:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < int'(AW); i++) begin
      if (v[i]) lzc27 = 5'(int'(AW) - 1 - i);
    end
  endfunction

  // Stage 1: unpack, classify, order operands so |x| >= |y|
  logic          a_nan, b_nan, a_inf, b_inf, a_big;
  logic [30:0]   key_a, key_b;
  logic          x_sign;
  logic [EW-1:0] x_exp, y_exp;
  logic [MW-1:0] x_mant, y_mant;
  logic          spec;
  logic [31:0]   spec_val;

  always_comb begin
    a_nan    = (a_in[30:23] == 8'hFF) && (a_in[22:0] != 23'd0);
    b_nan    = (b_in[30:23] == 8'hFF) && (b_in[22:0] != 23'd0);
    a_inf    = (a_in[30:23] == 8'hFF) && (a_in[22:0] == 23'd0);
    b_inf    = (b_in[30:23] == 8'hFF) && (b_in[22:0] == 23'd0);
    key_a    = (a_in[30:23] == 8'd0) ? 31'd0 : a_in[30:0];
    key_b    = (b_in[30:23] == 8'd0) ? 31'd0 : b_in[30:0];
    a_big    = key_a >= key_b;
    x_sign   = a_big ? a_in[31] : b_in[31];
    x_exp    = a_big ? key_a[30:23] : key_b[30:23];
    y_exp    = a_big ? key_b[30:23] : key_a[30:23];
    x_mant   = (x_exp == 8'd0) ? 24'd0 : {1'b1, (a_big ? key_a[22:0] : key_b[22:0])};
    y_mant   = (y_exp == 8'd0) ? 24'd0 : {1'b1, (a_big ? key_b[22:0] : key_a[22:0])};
    spec     = 1'b0;
    spec_val = 32'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_in[31] != b_in[31]))) begin
      spec     = 1'b1;
      spec_val = QNAN;
    end else if (a_inf) begin
      spec     = 1'b1;
      spec_val = a_in;
    end else if (b_inf) begin
      spec     = 1'b1;
      spec_val = b_in;
    end else if ((key_a == 31'd0) && (key_b == 31'd0)) begin
      spec     = 1'b1;
      spec_val = {a_in[31] & b_in[31], 31'd0};
    end
  end

  logic          s1_valid, s1_sign, s1_sub, s1_spec;
  logic [31:0]   s1_spec_val;
  logic [EW-1:0] s1_exp, s1_diff;
  logic [MW-1:0] s1_mx, s1_my;

  // Stage 2: align y with guard/round/sticky
  logic [4:0]       sh;
  logic [MW+29:0]   wide;
  logic [AW-1:0]    y_al;

  always_comb begin
    sh   = (s1_diff > 8'd27) ? 5'd27 : s1_diff[4:0];
    wide = {s1_my, 30'd0} >> sh;
    y_al = {wide[MW+29:28], wide[27] | (|wide[26:0])};
  end

  logic          s2_valid, s2_sign, s2_sub, s2_spec;
  logic [31:0]   s2_spec_val;
  logic [EW-1:0] s2_exp;
  logic [AW-1:0] s2_x, s2_y;

  // Stage 3: magnitude add/subtract (non-negative since |x| >= |y|)
  logic [SW-1:0] sum;
  always_comb begin
    sum = s2_sub ? ({1'b0, s2_x} - {1'b0, s2_y}) : ({1'b0, s2_x} + {1'b0, s2_y});
  end

  logic          s3_valid, s3_sign, s3_spec;
  logic [31:0]   s3_spec_val;
  logic [EW-1:0] s3_exp;
  logic [SW-1:0] s3_sum;

  // Stage 4: normalize
  logic [4:0]           lz;
  logic [AW-1:0]        norm;
  logic signed [XW-1:0] norm_exp;

  always_comb begin
    lz = lzc27(s3_sum[AW-1:0]);
    if (s3_sum[SW-1]) begin
      norm     = {s3_sum[SW-1:2], s3_sum[1] | s3_sum[0]};
      norm_exp = $signed({2'b00, s3_exp}) + 10'sd1;
    end else begin
      norm     = s3_sum[AW-1:0] << lz;
      norm_exp = $signed({2'b00, s3_exp}) - $signed({5'd0, lz});
    end
  end

  logic                 s4_valid, s4_sign, s4_spec, s4_zero;
  logic [31:0]          s4_spec_val;
  logic signed [XW-1:0] s4_exp;
  logic [AW-1:0]        s4_norm;

  // Stage 5: round to nearest even, range check, pack
  logic                 round_up;
  logic [MW:0]          rnd;
  logic signed [XW-1:0] rnd_exp;
  logic [22:0]          frac;
  logic [31:0]          result;

  always_comb begin
    round_up = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
    rnd      = {1'b0, s4_norm[AW-1:3]} + {24'd0, round_up};
    rnd_exp  = s4_exp + $signed({9'd0, rnd[MW]});
    frac     = rnd[MW] ? rnd[23:1] : rnd[22:0];
    if (s4_spec)                 result = s4_spec_val;
    else if (s4_zero)            result = 32'd0;
    else if (rnd_exp >= 10'sd255) result = {s4_sign, 8'hFF, 23'd0};
    else if (rnd_exp <= 10'sd0)  result = {s4_sign, 31'd0};
    else                         result = {s4_sign, rnd_exp[7:0], frac};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spec <= 1'b0;
      s1_spec_val <= '0; s1_exp <= '0; s1_diff <= '0; s1_mx <= '0; s1_my <= '0;
      s2_valid <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spec <= 1'b0;
      s2_spec_val <= '0; s2_exp <= '0; s2_x <= '0; s2_y <= '0;
      s3_valid <= 1'b0; s3_sign <= 1'b0; s3_spec <= 1'b0;
      s3_spec_val <= '0; s3_exp <= '0; s3_sum <= '0;
      s4_valid <= 1'b0; s4_sign <= 1'b0; s4_spec <= 1'b0; s4_zero <= 1'b0;
      s4_spec_val <= '0; s4_exp <= '0; s4_norm <= '0;
      valid_out <= 1'b0;
      c_out     <= '0;
    end else begin
      s1_valid    <= valid_in;
      s1_sign     <= x_sign;
      s1_sub      <= a_in[31] ^ b_in[31];
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_exp      <= x_exp;
      s1_diff     <= x_exp - y_exp;
      s1_mx       <= x_mant;
      s1_my       <= y_mant;

      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_sub      <= s1_sub;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_exp      <= s1_exp;
      s2_x        <= {s1_mx, 3'b000};
      s2_y        <= y_al;

      s3_valid    <= s2_valid;
      s3_sign     <= s2_sign;
      s3_spec     <= s2_spec;
      s3_spec_val <= s2_spec_val;
      s3_exp      <= s2_exp;
      s3_sum      <= sum;

      s4_valid    <= s3_valid;
      s4_sign     <= s3_sign;
      s4_spec     <= s3_spec;
      s4_spec_val <= s3_spec_val;
      s4_zero     <= (s3_sum == '0);
      s4_exp      <= norm_exp;
      s4_norm     <= norm;

      // Output held at zero between results so idle cycles read cleanly
      valid_out   <= s4_valid;
      c_out       <= s4_valid ? result : 32'd0;
    end
  end

endmodule

// File: tb/tb_fp32_add.sv
// Vector-table bench for fp32_add with a due-cycle scoreboard on the output side.
module tb_fp32_add;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [31:0] a_in, b_in;
  logic        valid_out;
  logic [31:0] c_out;

  fp32_add dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .valid_in (valid_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .valid_out(valid_out),
    .c_out    (c_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [31:0] val;
    int          id;
  } exp_t;

  localparam int NV = 20;
  vec_t        vecs [NV];
  exp_t        sb_q [$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  task automatic check_out();
    exp_t e;
    if (valid_out) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d c_out=%h required no output", cyc, c_out);
      end else begin
        e = sb_q.pop_front();
        if (e.due != cyc || c_out !== e.val) begin
          errors++;
          $display("FAIL result id=%0d cyc=%0d c_out=%h required %h at cyc %0d",
                   e.id, cyc, c_out, e.val, e.due);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing id=%0d cyc=%0d valid_out=0 required %h", e.id, cyc, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input int id);
    exp_t e;
    valid_in = 1'b1;
    a_in     = a;
    b_in     = b;
    e.due    = cyc + 5;
    e.val    = c;
    e.id     = id;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, act, req);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h43970FFD, 32'h40C91759, 32'h439A345A};
    vecs[1]  = '{32'h3DFFCB92, 32'h3FA45D64, 32'h3FB45A1D};
    vecs[2]  = '{32'hC141BE77, 32'h40E6C99B, 32'hC09CB353};
    vecs[3]  = '{32'h3DE31F8A, 32'hBDD53261, 32'h3BDED290};
    vecs[4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
    vecs[5]  = '{32'h80000000, 32'h80000000, 32'h80000000};
    vecs[6]  = '{32'h00000000, 32'h40490FDB, 32'h40490FDB};
    vecs[7]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[8]  = '{32'h3F800001, 32'h33800000, 32'h3F800002};
    vecs[9]  = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[10] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    vecs[11] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[13] = '{32'hFF800000, 32'h42C80000, 32'hFF800000};
    vecs[14] = '{32'h00800000, 32'h80000001, 32'h00800000};
    vecs[15] = '{32'h00800001, 32'h80800000, 32'h00000000};
    vecs[16] = '{32'h00000000, 32'h80000000, 32'h00000000};
    vecs[17] = '{32'h3F800000, 32'h00000001, 32'h3F800000};
    // tie at the last ulp below 1.0 rounds up into the next binade
    vecs[18] = '{32'h3F7FFFFF, 32'h33000000, 32'h3F800000};
    vecs[19] = '{32'h7F7FFFFF, 32'h73000000, 32'h7F800000};

    cyc      = 0;
    checks   = 0;
    errors   = 0;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;
    tick();
    tick();
    check_eq("reset_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("reset_c_out", c_out, 32'd0);
    rst_in = 1'b0;
    idle(2);

    // Four back-to-back ops, then a gap with no valid_out expected
    for (int i = 0; i < 4; i++) issue(vecs[i].a, vecs[i].b, vecs[i].c, i);
    idle(8);

    for (int i = 4; i < NV; i++) issue(vecs[i].a, vecs[i].b, vecs[i].c, i);
    idle(8);

    // Operands swapped: results must be bit-identical
    for (int i = 0; i < NV; i++) issue(vecs[i].b, vecs[i].a, vecs[i].c, 100 + i);
    idle(8);

    // Reset with three ops in flight and an op presented during reset
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in = vecs[i].a;
      b_in = vecs[i].b;
      tick();
    end
    rst_in = 1'b1;
    a_in   = 32'h3F800000;
    b_in   = 32'h3F800000;
    tick();
    check_eq("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("rst_c_out", c_out, 32'd0);
    sb_q.delete();
    rst_in = 1'b0;
    issue(vecs[8].a, vecs[8].b, vecs[8].c, 200);
    valid_in = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;
    for (int i = 0; i < 4; i++) begin
      check_eq("post_rst_valid_out", {31'd0, valid_out}, 32'd0);
      check_eq("post_rst_c_out", c_out, 32'd0);
      tick();
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb_q.size());
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
